// File: rtl/fdc_phase_ctrl.sv
// Floppy controller command/execution/result phase sequencer.
// Decodes host MSR and data-port accesses and drives the execution engine.
module fdc_phase_ctrl #(
  parameter logic [19:0] MSR_ADDR  = 20'h003F4,
  parameter logic [19:0] DATA_ADDR = 20'h003F5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic        aen,
  input  logic [19:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        exec_start,
  output logic [4:0]  exec_cmd,
  output logic [71:0] cmd_buf,
  input  logic        exec_done,
  input  logic [55:0] res_in,
  output logic        irq6
);
  typedef enum logic [1:0] {S_CMD, S_EXEC, S_RES} state_e;

  localparam logic [4:0] C_READ  = 5'h06;
  localparam logic [4:0] C_WRITE = 5'h05;
  localparam logic [4:0] C_FMT   = 5'h0D;
  localparam logic [4:0] C_SEEK  = 5'h0F;
  localparam logic [4:0] C_SPEC  = 5'h03;
  localparam logic [4:0] C_RECAL = 5'h07;
  localparam logic [4:0] C_SENSE = 5'h08;

  state_e     state_q;
  logic       iow_q, ior_q, rsel_q;
  logic [7:0] cmd_q [9];
  logic [3:0] cidx_q;
  logic [7:0] res_q [8];
  logic [2:0] ridx_q, rlen_q;
  logic [7:0] st0_q, pcn_q;
  logic       ipend_q, irq_q, start_q, rclr_q;

  function automatic logic [3:0] cmd_len(input logic [4:0] c);
    case (c)
      C_READ, C_WRITE: cmd_len = 4'd9;
      C_FMT:           cmd_len = 4'd6;
      C_SEEK, C_SPEC:  cmd_len = 4'd3;
      C_RECAL:         cmd_len = 4'd2;
      default:         cmd_len = 4'd1;
    endcase
  endfunction

  function automatic logic is_rwf(input logic [4:0] c);
    is_rwf = (c == C_READ) || (c == C_WRITE) || (c == C_FMT);
  endfunction

  function automatic logic is_seek(input logic [4:0] c);
    is_seek = (c == C_SEEK) || (c == C_RECAL);
  endfunction

  logic       dsel, msel, wr_stb, pop, last;
  logic [4:0] code, cur;
  logic [7:0] msr;

  assign dsel   = !aen && (a == DATA_ADDR);
  assign msel   = !aen && (a == MSR_ADDR);
  assign wr_stb = dsel && !iow_n && iow_q;
  // rsel_q holds the decode from the cycle before ior_n rose
  assign pop    = ior_n && !ior_q && rsel_q;
  assign cur    = cmd_q[0][4:0];
  assign code   = (cidx_q == 4'd0) ? din[4:0] : cur;
  assign last   = (cidx_q + 4'd1) == cmd_len(code);

  always_comb begin
    msr = 8'h80;
    case (state_q)
      S_CMD:   msr = (cidx_q == 4'd0) ? 8'h80 : 8'h90;
      S_EXEC:  msr = 8'h10;
      S_RES:   msr = 8'hD0;
      default: msr = 8'h80;
    endcase
  end

  always_comb begin
    dout = 8'hFF;
    if (msel)
      dout = msr;
    else if (dsel && state_q == S_RES)
      dout = res_q[ridx_q];
  end

  assign dout_en    = !ior_n && (msel || dsel);
  assign exec_start = start_q;
  assign exec_cmd   = cur;
  assign irq6       = irq_q;

  for (genvar k = 0; k < 9; k++) begin : g_cb
    assign cmd_buf[8*k +: 8] = cmd_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      iow_q   <= 1'b1;
      ior_q   <= 1'b1;
      rsel_q  <= 1'b0;
      for (int k = 0; k < 9; k++) cmd_q[k] <= '0;
      for (int k = 0; k < 8; k++) res_q[k] <= '0;
      cidx_q  <= '0;
      ridx_q  <= '0;
      rlen_q  <= '0;
      st0_q   <= '0;
      pcn_q   <= '0;
      ipend_q <= 1'b0;
      irq_q   <= 1'b0;
      start_q <= 1'b0;
      rclr_q  <= 1'b0;
    end else begin
      iow_q   <= iow_n;
      ior_q   <= ior_n;
      rsel_q  <= dsel;
      start_q <= 1'b0;
      unique case (state_q)
        S_CMD: if (wr_stb) begin
          cmd_q[cidx_q] <= din;
          cidx_q <= cidx_q + 4'd1;
          if (last) begin
            cidx_q <= '0;
            ridx_q <= '0;
            if (is_rwf(code) || is_seek(code)) begin
              state_q <= S_EXEC;
              start_q <= 1'b1;
            end else if (code != C_SPEC) begin
              state_q  <= S_RES;
              rlen_q   <= 3'd1;
              res_q[0] <= 8'h80;
              if (code == C_SENSE && ipend_q) begin
                res_q[0] <= st0_q;
                res_q[1] <= pcn_q;
                rlen_q   <= 3'd2;
                ipend_q  <= 1'b0;
                irq_q    <= 1'b0;
              end
            end
          end
        end
        S_EXEC: if (exec_done) begin
          ridx_q <= '0;
          irq_q  <= 1'b1;
          if (is_rwf(cur)) begin
            for (int k = 0; k < 7; k++) res_q[k] <= res_in[55-8*k -: 8];
            rlen_q  <= 3'd7;
            rclr_q  <= 1'b1;
            state_q <= S_RES;
          end else begin
            st0_q   <= res_in[55:48];
            pcn_q   <= res_in[31:24];
            ipend_q <= 1'b1;
            state_q <= S_CMD;
          end
        end
        S_RES: if (pop) begin
          ridx_q <= ridx_q + 3'd1;
          if (rclr_q) begin
            irq_q  <= 1'b0;
            rclr_q <= 1'b0;
          end
          if (ridx_q + 3'd1 == rlen_q) begin
            state_q <= S_CMD;
            ridx_q  <= '0;
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end
endmodule

// File: tb/tb_fdc_phase_ctrl.sv
// Scoreboard bench for fdc_phase_ctrl: directed scenarios then random
// command streams checked against a queue-based phase model.
module tb_fdc_phase_ctrl;
  localparam logic [19:0] MA = 20'h003F4;
  localparam logic [19:0] DA = 20'h003F5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ior_n = 1'b1;
  logic        iow_n = 1'b1;
  logic        aen = 1'b0;
  logic [19:0] a = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        dout_en;
  logic        exec_start;
  logic [4:0]  exec_cmd;
  logic [71:0] cmd_buf;
  logic        exec_done = 1'b0;
  logic [55:0] res_in = '0;
  logic        irq6;

  fdc_phase_ctrl #(.MSR_ADDR(MA), .DATA_ADDR(DA)) dut (
    .clk(clk), .rst(rst), .ior_n(ior_n), .iow_n(iow_n), .aen(aen),
    .a(a), .din(din), .dout(dout), .dout_en(dout_en),
    .exec_start(exec_start), .exec_cmd(exec_cmd), .cmd_buf(cmd_buf),
    .exec_done(exec_done), .res_in(res_in), .irq6(irq6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       irq;
    string      nm;
  } rd_t;

  typedef struct {
    logic [4:0]  code;
    int          len;
    logic [71:0] bytes;
  } ex_t;

  rd_t rd_q[$];
  ex_t ex_q[$];

  function automatic void chk(string nm, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Reference model: phase, pending bytes, pending results.
  int         m_ph;
  logic [7:0] m_cmd[$];
  logic [7:0] m_res[$];
  bit         m_ip, m_irq, m_clr;
  logic [7:0] m_st0, m_pcn;
  logic [4:0] m_code;

  function automatic int clen(logic [4:0] c);
    case (c)
      5'h06, 5'h05: return 9;
      5'h0D:        return 6;
      5'h0F, 5'h03: return 3;
      5'h07:        return 2;
      default:      return 1;
    endcase
  endfunction

  function automatic bit rwf(logic [4:0] c);
    return c == 5'h06 || c == 5'h05 || c == 5'h0D;
  endfunction

  function automatic bit skr(logic [4:0] c);
    return c == 5'h0F || c == 5'h07;
  endfunction

  function automatic logic [7:0] m_msr();
    if (m_ph == 1) return 8'h10;
    if (m_ph == 2) return 8'hD0;
    return (m_cmd.size() != 0) ? 8'h90 : 8'h80;
  endfunction

  function automatic void m_reset();
    m_ph = 0;
    m_cmd.delete();
    m_res.delete();
    m_ip = 0;
    m_irq = 0;
    m_clr = 0;
    m_st0 = '0;
    m_pcn = '0;
    m_code = '0;
  endfunction

  function automatic void m_write(logic [7:0] b);
    ex_t e;
    logic [4:0] c;
    if (m_ph != 0) return;
    m_cmd.push_back(b);
    c = m_cmd[0][4:0];
    if (m_cmd.size() < clen(c)) return;
    m_code = c;
    if (rwf(c) || skr(c)) begin
      e.code = c;
      e.len = m_cmd.size();
      e.bytes = '0;
      foreach (m_cmd[i]) e.bytes[8*i +: 8] = m_cmd[i];
      ex_q.push_back(e);
      m_ph = 1;
    end else if (c != 5'h03) begin
      m_ph = 2;
      m_res.delete();
      if (c == 5'h08 && m_ip) begin
        m_res.push_back(m_st0);
        m_res.push_back(m_pcn);
        m_ip = 0;
        m_irq = 0;
      end else begin
        m_res.push_back(8'h80);
      end
    end
    m_cmd.delete();
  endfunction

  function automatic void m_done(logic [55:0] r);
    if (m_ph != 1) return;
    m_irq = 1;
    if (rwf(m_code)) begin
      m_res.delete();
      for (int k = 0; k < 7; k++) m_res.push_back(r[55-8*k -: 8]);
      m_clr = 1;
      m_ph = 2;
    end else begin
      m_st0 = r[55:48];
      m_pcn = r[31:24];
      m_ip = 1;
      m_ph = 0;
    end
  endfunction

  function automatic logic [7:0] m_pop();
    logic [7:0] v;
    if (m_ph != 2) return 8'hFF;
    v = m_res.pop_front();
    if (m_clr) begin
      m_irq = 0;
      m_clr = 0;
    end
    if (m_res.size() == 0) m_ph = 0;
    return v;
  endfunction

  task automatic wr(logic [7:0] b, logic ae = 1'b0);
    @(posedge clk); #1;
    a = DA; aen = ae; din = b; iow_n = 1'b0;
    if (!ae) m_write(b);
    @(posedge clk); #1;
    iow_n = 1'b1;
    @(posedge clk); #1;
    aen = 1'b0;
  endtask

  task automatic rd(logic [19:0] ad, string nm);
    rd_t r;
    @(posedge clk); #1;
    a = ad; aen = 1'b0; ior_n = 1'b0;
    r.irq = m_irq;
    r.nm = nm;
    if (ad == MA) r.d = m_msr();
    else r.d = m_pop();
    rd_q.push_back(r);
    repeat (2) @(posedge clk);
    #1 ior_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rd_noen(logic [19:0] ad);
    @(posedge clk); #1;
    a = ad; aen = 1'b1; ior_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ior_n = 1'b1;
    @(posedge clk); #1;
    aen = 1'b0;
  endtask

  task automatic done(logic [55:0] r);
    @(posedge clk); #1;
    res_in = r; exec_done = 1'b1;
    @(posedge clk); #1;
    exec_done = 1'b0;
    m_done(r);
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares every host read and every exec_start pulse.
  logic        prev_ior = 1'b1;
  logic        exp_en;
  rd_t         mr;
  ex_t         me;
  logic [71:0] mask;

  always @(negedge clk) begin
    if (!rst) begin
      if (!ior_n && prev_ior) begin
        exp_en = !aen && (a == MA || a == DA);
        chk("dout_en", {71'd0, dout_en}, {71'd0, exp_en});
        if (dout_en) begin
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read_unexpected actual=%0h required=none", dout);
          end else begin
            mr = rd_q.pop_front();
            chk({mr.nm, "_dout"}, {64'd0, dout}, {64'd0, mr.d});
            chk({mr.nm, "_irq6"}, {71'd0, irq6}, {71'd0, mr.irq});
          end
        end
      end
      if (exec_start) begin
        if (ex_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL exec_start_unexpected actual=1 required=0");
        end else begin
          me = ex_q.pop_front();
          mask = '0;
          for (int i = 0; i < me.len; i++) mask[8*i +: 8] = 8'hFF;
          chk("exec_cmd", {67'd0, exec_cmd}, {67'd0, me.code});
          chk("cmd_buf", cmd_buf & mask, me.bytes);
        end
      end
    end
    prev_ior = ior_n;
  end

  initial begin
    logic [7:0] sq1 [9];
    logic [7:0] inv [6];
    logic [4:0] c;
    logic [7:0] b;
    int n, pick, cut;
    sq1 = '{8'h06, 8'h01, 8'h01, 8'h00, 8'h01, 8'h02, 8'h07, 8'h2A, 8'hFF};
    inv = '{8'h00, 8'h01, 8'h0A, 8'h10, 8'h11, 8'h1F};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec_start", {71'd0, exec_start}, 72'd0);
    chk("rst_irq6", {71'd0, irq6}, 72'd0);
    chk("rst_cmd_buf", cmd_buf, 72'd0);
    rst = 1'b0;

    rd(MA, "msr_idle");
    wr(sq1[0]);
    rd(MA, "msr_after_b0");
    for (int i = 1; i < 9; i++) wr(sq1[i]);
    rd(MA, "msr_exec");
    done(56'h01_00_00_01_00_02_02);
    rd(MA, "msr_result");
    for (int i = 0; i < 7; i++) rd(DA, "read_res");
    rd(MA, "msr_read_end");

    wr(8'h0F); wr(8'h00); wr(8'h05);
    done({8'h20, 16'h0000, 8'h05, 24'h000000});
    rd(MA, "msr_seek_done");
    wr(8'h08);
    rd(MA, "msr_sense");
    rd(DA, "sense_st0");
    rd(DA, "sense_pcn");
    wr(8'h08);
    rd(DA, "sense_none");
    rd(MA, "msr_sense_end");

    wr(8'h03); wr(8'hDF); wr(8'h02);
    rd(MA, "msr_specify");
    wr(8'h1F);
    rd(MA, "msr_invalid");
    rd(DA, "invalid_res");
    rd(MA, "msr_invalid_end");

    for (int i = 0; i < 4; i++) wr(sq1[i]);
    do_rst();
    rd(MA, "msr_after_rst");
    rd(DA, "data_in_cmd");
    wr(8'h08, 1'b1);
    rd(MA, "msr_aen_write");
    rd_noen(MA);

    for (int it = 0; it < 60; it++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0: c = 5'h06;
        1: c = 5'h05;
        2: c = 5'h0D;
        3: c = 5'h0F;
        4: c = 5'h03;
        5: c = 5'h07;
        6, 7: c = 5'h08;
        default: c = inv[$urandom_range(0, 5)][4:0];
      endcase
      n = clen(c);
      cut = (pick == 9) ? $urandom_range(1, n) : n + 1;
      if (pick == 9) begin
        c = 5'h05;
        n = 9;
        cut = $urandom_range(1, 8);
      end
      for (int j = 0; j < n; j++) begin
        if (j == cut) break;
        b = (j == 0) ? {3'($urandom), c} : 8'($urandom);
        if ($urandom_range(0, 5) == 0) wr(8'($urandom), 1'b1);
        if ($urandom_range(0, 6) == 0 && j != 0) rd(DA, "rnd_data_cmd");
        wr(b);
        if ($urandom_range(0, 3) == 0) rd(MA, "rnd_msr_cmd");
      end
      if (pick == 9) begin
        do_rst();
        rd(MA, "rnd_msr_rst");
      end
      if (m_ph == 1) begin
        if ($urandom_range(0, 2) == 0) wr(8'($urandom));
        rd(MA, "rnd_msr_exec");
        repeat ($urandom_range(0, 5)) @(posedge clk);
        done(56'({$urandom, $urandom}));
        rd(MA, "rnd_msr_done");
      end
      for (int k = 0; k < 10; k++) begin
        if (m_ph != 2) break;
        if ($urandom_range(0, 2) == 0) rd(MA, "rnd_msr_res");
        rd(DA, "rnd_res");
      end
      if (m_ph == 0 && $urandom_range(0, 7) == 0) done(56'({$urandom, $urandom}));
      rd(MA, "rnd_msr_idle");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rd_q_drained", 72'(rd_q.size()), 72'd0);
    chk("ex_q_drained", 72'(ex_q.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
